// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared mode encodings and channel slice helper for stream_mux
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Upper bounds for the slice helper; callers zero-extend the bus and truncate the result.
  localparam int MAX_BUS = 1024;
  localparam int MAX_W   = 64;

  function automatic logic [MAX_W-1:0] chan_slice(input logic [MAX_BUS-1:0] bus,
                                                  input int ch, input int w);
    return MAX_W'(bus >> (ch * w));
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rtl/stream_mux_rr_arbiter.sv - combinational round-robin search starting at ptr, wrapping modulo N
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          en,
  output logic          gnt_valid,
  output logic [SW-1:0] gnt
);

  logic [SW-1:0] cand;

  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    cand      = '0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        cand = SW'((int'(ptr) + k) % N);
        if (!gnt_valid && req[cand]) begin
          gnt_valid = 1'b1;
          gnt       = cand;
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// rtl/stream_mux.sv - registered N-channel stream mux, fixed-select or round-robin
// Optional packet lock on in_last enabled by STREAM_MUX_LAST_LOCK_EN.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic [SW-1:0]  select,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
`ifdef STREAM_MUX_LAST_LOCK_EN
  input  logic [N-1:0]   in_last,
  output logic           out_last,
`endif
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int SEL_SPAN = 1 << SW;

  logic [SW-1:0]       ptr;
  logic [SW-1:0]       ptr_next;
  logic                ptr_adv;
  logic                rr_valid;
  logic [SW-1:0]       rr_gnt;
  logic                gnt_valid;
  logic [SW-1:0]       gnt;
  logic                load;
  logic                xfer;
  // Zero-extended so an out-of-range select indexes a 0 and yields no grant.
  logic [SEL_SPAN-1:0] valid_ext;

`ifdef STREAM_MUX_LAST_LOCK_EN
  logic                lock;
  logic [SW-1:0]       lock_ch;
  assign ptr_adv = in_last[gnt];
`else
  assign ptr_adv = 1'b1;
`endif

  rr_arbiter #(.N(N)) u_arb (
    .req      (in_valid),
    .ptr      (ptr),
    .en       (mode == MODE_RR),
    .gnt_valid(rr_valid),
    .gnt      (rr_gnt)
  );

  assign valid_ext = SEL_SPAN'(in_valid);
  assign load      = !out_valid || out_ready;

  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    if (mode == MODE_RR) begin
      gnt_valid = rr_valid;
      gnt       = rr_gnt;
    end else begin
      gnt_valid = valid_ext[select];
      gnt       = select;
    end
`ifdef STREAM_MUX_LAST_LOCK_EN
    if (lock) begin
      gnt_valid = in_valid[lock_ch];
      gnt       = lock_ch;
    end
`endif
  end

  // rst_n gating keeps every ready low for the whole time reset is held.
  assign xfer     = rst_n && load && gnt_valid;
  assign ptr_next = (gnt == SW'(N - 1)) ? '0 : gnt + 1'b1;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
`ifdef STREAM_MUX_LAST_LOCK_EN
      out_last  <= 1'b0;
      lock      <= 1'b0;
      lock_ch   <= '0;
`endif
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= W'(chan_slice(MAX_BUS'(in_data), int'(gnt), W));
      out_ch    <= gnt;
      if (mode == MODE_RR && ptr_adv) ptr <= ptr_next;
`ifdef STREAM_MUX_LAST_LOCK_EN
      out_last  <= in_last[gnt];
      lock      <= !in_last[gnt];
      lock_ch   <= gnt;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux.sv
// tb/tb_stream_mux.sv - directed and randomized checks of stream_mux against a behavioural model
module tb_stream_mux;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mode = 1'b0;
  logic [SW-1:0]  select = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready = 1'b0;
`ifdef STREAM_MUX_LAST_LOCK_EN
  logic [N-1:0]   in_last = '1;
  logic           out_last;
  bit             m_last, m_lock;
  int             m_lock_ch;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit m_valid;
  int m_data, m_ch, m_ptr;

  always #5 clk = ~clk;

  stream_mux #(.W(W), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .select   (select),
    .in_data  (in_data),
    .in_valid (in_valid),
`ifdef STREAM_MUX_LAST_LOCK_EN
    .in_last  (in_last),
    .out_last (out_last),
`endif
    .in_ready (in_ready),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_data = 0; m_ch = 0; m_ptr = 0;
`ifdef STREAM_MUX_LAST_LOCK_EN
    m_last = 1'b0; m_lock = 1'b0; m_lock_ch = 0;
`endif
  endtask

  // Channel the spec's grant rules pick right now, or -1 for none.
  function automatic int model_grant();
    int g = -1;
    int c;
`ifdef STREAM_MUX_LAST_LOCK_EN
    if (m_lock) return in_valid[SW'(m_lock_ch)] ? m_lock_ch : -1;
`endif
    if (mode == 1'b0) return in_valid[select] ? int'(select) : -1;
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (g < 0 && in_valid[SW'(c)]) g = c;
    end
    return g;
  endfunction

  task automatic step(input string tag);
    int g;
    bit ld;
    logic [N-1:0] exp_ready;
    #1;
    ld = !m_valid || out_ready;
    g = model_grant();
    exp_ready = '0;
    if (ld && g >= 0) exp_ready[SW'(g)] = 1'b1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
    @(posedge clk);
    #1;
    if (ld && g >= 0) begin
      m_valid = 1'b1;
      m_data  = int'(in_data[g*W +: W]);
      m_ch    = g;
`ifdef STREAM_MUX_LAST_LOCK_EN
      m_last    = in_last[SW'(g)];
      m_lock    = !in_last[SW'(g)];
      m_lock_ch = g;
      if (mode && in_last[SW'(g)]) m_ptr = (g + 1) % N;
`else
      if (mode) m_ptr = (g + 1) % N;
`endif
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".out_data"}, 32'(out_data), m_data);
    chk({tag, ".out_ch"}, 32'(out_ch), m_ch);
`ifdef STREAM_MUX_LAST_LOCK_EN
    chk({tag, ".out_last"}, 32'(out_last), 32'(m_last));
`endif
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    in_valid = '1;
    in_data  = 32'h1312_1110;
    #1;
    chk("reset.in_ready", 32'(in_ready), 0);
    chk("reset.out_valid", 32'(out_valid), 0);
    chk("reset.out_data", 32'(out_data), 0);
    chk("reset.out_ch", 32'(out_ch), 0);
    @(negedge clk);
    rst_n = 1'b1;

    mode = 1'b0; select = 2'd2; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("fixed_sel2");
      chk("fixed_sel2.const_data", 32'(out_data), 32'h12);
    end
    select = 2'd3; in_valid = 4'b0111;
    step("fixed_nogrant");
    chk("fixed_nogrant.drop", 32'(out_valid), 0);

    mode = 1'b1; in_valid = '1;
    for (int i = 0; i < 8; i++) begin
      step("rr_all");
      chk("rr_all.seq", 32'(out_ch), i % N);
    end
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step("rr_1_3");
      chk("rr_1_3.seq", 32'(out_ch), (i % 2 == 0) ? 1 : 3);
    end

    in_valid = 4'b0010;
    step("bp_load");
    in_valid = '1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("bp_stall");
      chk("bp_stall.hold", 32'(out_data), 32'h11);
    end
    out_ready = 1'b1;
    step("bp_release");
    chk("bp_release.next", 32'(out_ch), 2);

    out_ready = 1'b0;
    step("pre_reset_stall");
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_reset.out_valid", 32'(out_valid), 0);
    chk("mid_reset.in_ready", 32'(in_ready), 0);
    chk("mid_reset.out_data", 32'(out_data), 0);
    chk("mid_reset.out_ch", 32'(out_ch), 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
`ifdef STREAM_MUX_LAST_LOCK_EN
    in_valid = 4'b0011;
    for (int b = 0; b < 4; b++) begin
      in_last = {3'b000, b == 2};
      step("lock");
      chk("lock.ch", 32'(out_ch), (b < 3) ? 0 : 1);
      chk("lock.last", 32'(out_last), (b == 2) ? 1 : 0);
    end
`else
    step("rr_after_reset");
    chk("rr_after_reset.ch0", 32'(out_ch), 0);
`endif

    for (int i = 0; i < 400; i++) begin
      mode      = 1'($urandom);
      select    = SW'($urandom);
      in_valid  = N'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef STREAM_MUX_LAST_LOCK_EN
      in_last   = N'($urandom);
`endif
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_mux.md
Name: stream_mux

Overview:
- Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshake on every input and on the output.
- Two run-time modes:
  - fixed select (software-steered channel choice);
  - round-robin arbitration across all requesting channels.
- Sits between producer blocks and a single downstream consumer in the datapath.
- Output is registered, so one beat moves per cycle with no combinational path from input data to output data.

Parameters:
- W, default 8: data width per channel.
- N, default 4: number of input channels, N >= 2.
- SW, default $clog2(N): width of SELECT and OUT_CH. Derived; never overridden.

Ports:
- CLK, input, 1: rising-edge clock.
- RST_N, input, 1: asynchronous active-low reset.
- MODE, input, 1: 0 = fixed select, 1 = round-robin.
- SELECT, input, SW: channel chosen in fixed mode.
- IN_DATA, input, N*W: channel i occupies bits [i*W +: W].
- IN_VALID, input, N: per-channel valid.
- IN_READY, output, N: per-channel ready, at most one bit high.
- OUT_DATA, output, W: registered data.
- OUT_CH, output, SW: source channel of the current OUT_DATA.
- OUT_VALID, output, 1: output beat valid.
- OUT_READY, input, 1: downstream ready.

Behaviour:
- Reset (RST_N low, takes effect immediately):
  - OUT_VALID=0, OUT_DATA=0, OUT_CH=0;
  - round-robin pointer PTR=0;
  - any held beat is discarded;
  - IN_READY=0 while reset is asserted.
- load = !OUT_VALID || OUT_READY. This is the output register accept condition.
- Grant decision is combinational in the same cycle:
  - Fixed mode: the grant is SELECT, valid only when SELECT < N and IN_VALID[SELECT]=1. Out-of-range SELECT gives no grant.
  - Round-robin mode: the grant is the first channel with IN_VALID=1, searching PTR, PTR+1, ..., wrapping modulo N.
- IN_READY[i] = load && grant valid && grant == i. All other channels stay 0.
- Transfer on IN_VALID[g] && IN_READY[g]:
  - at the next edge, OUT_DATA <= channel g data, OUT_CH <= g, OUT_VALID <= 1;
  - in round-robin mode only, PTR <= (g+1) mod N. PTR also wraps for non-power-of-2 N.
- No transfer and OUT_READY=1: OUT_VALID <= 0. OUT_DATA and OUT_CH hold their values.
- Latency and throughput: latency is 1 cycle input-to-output. Full throughput is 1 beat/cycle while OUT_READY=1.
- Stall (OUT_VALID && !OUT_READY):
  - OUT_DATA and OUT_CH are stable;
  - all IN_READY are 0;
  - no beat is lost or duplicated.
- MODE or SELECT change: takes effect on the next grant decision. PTR is retained across mode changes and is not updated in fixed mode.
- No input valid: nothing is granted. PTR is unchanged.

Optional Feature:
- Macro STREAM_MUX_LAST_LOCK_EN.
- Defined:
  - adds ports IN_LAST (input, N) and OUT_LAST (output, 1, reset 0);
  - OUT_LAST is registered alongside OUT_DATA;
  - after a transfer from channel g with IN_LAST[g]=0, the grant is locked to g in both modes, and SELECT and PTR are ignored;
  - the lock releases after the transfer of a beat with IN_LAST[g]=1;
  - PTR updates only when the lock releases;
  - reset clears the lock.
- Undefined: no IN_LAST or OUT_LAST ports, and every beat is arbitrated independently.

Decomposition:
- Package stream_mux_pkg holds:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1;
  - a helper function for channel slice extraction.
- Sub-module rr_arbiter (parameter N):
  - inputs REQ[N], PTR, EN;
  - outputs GNT_VALID and GNT index;
  - it is purely combinational;
  - PTR is owned by stream_mux.

Test Plan:
- Reset: assert RST_N low mid-stall with OUT_VALID=1 -> OUT_VALID=0 and IN_READY=0 immediately, OUT_DATA=0. After release, the first RR grant is ch0.
- Fixed mode: N=4, W=8, SELECT=2, all valid, ch i data = 0x10+i, OUT_READY=1 -> from cycle 1 on, OUT_DATA=0x12 and OUT_CH=2 every cycle; only IN_READY[2]=1. With SELECT=3 and IN_VALID[3]=0 -> no grant, and OUT_VALID drops next cycle.
- Round-robin, all channels valid continuously -> OUT_CH sequence 0,1,2,3,0,1 and OUT_DATA 0x10,0x11,0x12,0x13,0x10.
- Round-robin, only ch1 and ch3 valid -> OUT_CH alternates 1,3,1,3 with no idle cycles.
- Backpressure: OUT_READY=0 for 3 cycles while OUT_DATA=0x11 -> value is stable and IN_READY=0. On release, the next beat is ch2; no loss or duplication is seen on a scoreboard.
- With STREAM_MUX_LAST_LOCK_EN: ch0 sends 3 beats with IN_LAST on the third, ch1 valid throughout, RR mode -> OUT_CH 0,0,0,1, and OUT_LAST=1 only on the third beat.
